param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits and SHALL accept any value of 2 or more.
REQ-002 Parameter SATURATE, default 0, SHALL select the end-of-range mode: 0 = wrap, 1 = saturate.
REQ-003 Ports SHALL be exactly as follows, and the block SHALL use one clock with an asynchronous, active-low reset:
  clk       in   1      rising-edge clock
  rst_n     in   1      asynchronous active-low reset
  ld        in   1      synchronous load strobe
  ld_val    in   WIDTH  load value
  en        in   1      count enable
  dir       in   1      direction: 1 = up (+1), 0 = down (-1)
  clr_err   in   1      clears the sticky error flag
  q         out  WIDTH  registered count
  tc        out  1      terminal count, combinational
  edge_p    out  1      registered one-cycle end-of-range pulse
  err       out  1      registered sticky end-of-range flag

Function
REQ-004 The next-state value SHALL be computed by a WIDTH-bit ripple carry/borrow chain, using carry-in 1 for both up and down counting.
REQ-005 Update priority on each rising clk edge SHALL be ld, then en, then hold.
REQ-006 When ld=1, q SHALL take ld_val, and edge_p SHALL be 0 on the following cycle.
REQ-007 When ld=0 and en=1 with dir=1, q SHALL become q+1 modulo 2^WIDTH.
REQ-008 When ld=0 and en=1 with dir=0, q SHALL become q-1 modulo 2^WIDTH.
REQ-009 When ld=0 and en=0, q SHALL hold its value, and edge_p SHALL be 0 on the following cycle.
REQ-010 tc SHALL equal (dir=1 and q = 2^WIDTH-1) or (dir=0 and q = 0); tc SHALL be independent of en.
REQ-011 An end-of-range event SHALL be defined as ld=0, en=1 and tc=1 at a clock edge.
REQ-012 With SATURATE=0, an end-of-range event SHALL wrap q: up from all-ones to 0, down from 0 to all-ones.
REQ-013 With SATURATE=1, an end-of-range event SHALL leave q unchanged.
REQ-014 edge_p SHALL be 1 for exactly the one cycle following each end-of-range event and 0 otherwise.
REQ-015 Back-to-back end-of-range events (saturate mode, en held high) SHALL keep edge_p high on every such cycle.
REQ-016 err SHALL be set on any end-of-range event and SHALL remain set until cleared.
REQ-017 err SHALL be cleared on a clock edge where clr_err=1 and no end-of-range event occurs.
REQ-018 If an end-of-range event and clr_err=1 occur on the same edge, err SHALL end up 1 (set wins).
REQ-019 A change of dir while en=1 SHALL take effect on the next edge with no dead cycle.
REQ-020 q, edge_p and err SHALL all be registered outputs; tc SHALL be the only combinational output.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately force q=0, edge_p=0 and err=0, without waiting for clk.
REQ-022 While rst_n=0, all inputs SHALL be ignored, and the count SHALL not advance.
REQ-023 The first clock edge after rst_n rises SHALL be processed normally.
REQ-024 Reset asserted mid-count SHALL discard any pending ld or en action from that cycle.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (WIDTH=8 unless stated):
- Reset, then en=1, dir=1 for 3 cycles -> q=1, 2, 3; tc=0; edge_p=0; err=0.
- SATURATE=0: ld_val=8'hFE, then en=1, dir=1 for 3 edges -> q=FF, 00, 01; edge_p=1 only in the cycle q=00; err=1 and held.
- SATURATE=1: q=0, dir=0, en=1 for 3 edges -> q stays 00; tc=1; edge_p high for all 3 cycles; err=1.
- ld=1 and en=1 on the same edge with ld_val=8'h5A -> q=5A, edge_p=0; with clr_err=1 together with a wrap edge -> err stays 1.
- rst_n pulsed low between edges while q=8'h37 and err=1 -> q=0 and err=0 before the next edge; a pending ld of 8'hAA is dropped.
- WIDTH=4, SATURATE=0: dir toggled each cycle starting from q=4'h0 with en=1 -> q=F, 0, F, 0; edge_p=1 every cycle.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with load, wrap or saturate at the end of
// range, a one-cycle end-of-range pulse and a sticky end-of-range flag.
module param_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             dir,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             edge_p,
    output logic             err
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             edge_q, edge_d;
    logic             err_q, err_d;

    // Incrementer chain operands. Counting down reuses the same +1 chain:
    // q-1 == ~(~q + 1), so the operand and result are inverted when dir=0.
    logic [WIDTH-1:0] chain_a;
    logic [WIDTH-1:0] chain_c;
    logic [WIDTH-1:0] chain_s;
    logic [WIDTH-1:0] step_val;
    logic             eor;

    assign chain_a    = dir ? q_q : ~q_q;
    assign chain_c[0] = 1'b1;

    // Ripple chain: each bit is a half adder fed by the carry/borrow below it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            assign chain_s[gi] = chain_a[gi] ^ chain_c[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign chain_c[gi+1] = chain_a[gi] & chain_c[gi];
            end
        end
    endgenerate

    assign step_val = dir ? chain_s : ~chain_s;

    // Terminal count looks only at the current value and direction.
    assign tc  = dir ? (&q_q) : ~(|q_q);
    // An end-of-range event is a count step attempted at the terminal value.
    assign eor = ~ld & en & tc;

    // Next-state selection: load beats count beats hold; saturation blocks
    // the step only on an end-of-range event.
    always_comb begin
        q_d    = q_q;
        edge_d = eor;
        err_d  = err_q;
        if (ld) begin
            q_d = ld_val;
        end else if (en) begin
            if (!(eor && (SATURATE != 0))) begin
                q_d = step_val;
            end
        end
        if (eor) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            edge_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            edge_q <= edge_d;
            err_q  <= err_d;
        end
    end

    assign q      = q_q;
    assign edge_p = edge_q;
    assign err    = err_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three instances (8-bit wrap, 8-bit saturate,
// 4-bit wrap) share one stimulus stream; a behavioural model pushes expected
// outputs into a scoreboard queue, popped and compared after each edge.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld, en, dir, clr_err;
    logic [7:0] ld_val;
    logic [3:0] ld_val4;

    logic [7:0] q8, qs;
    logic [3:0] q4;
    logic       tc8, tcs, tc4;
    logic       e8, es, e4;
    logic       err8, errs, err4;

    assign ld_val4 = ld_val[3:0];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(8), .SATURATE(0)) u_w8s0 (
        .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val(ld_val), .en(en), .dir(dir),
        .clr_err(clr_err), .q(q8), .tc(tc8), .edge_p(e8), .err(err8));

    param_updown_counter #(.WIDTH(8), .SATURATE(1)) u_w8s1 (
        .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val(ld_val), .en(en), .dir(dir),
        .clr_err(clr_err), .q(qs), .tc(tcs), .edge_p(es), .err(errs));

    param_updown_counter #(.WIDTH(4), .SATURATE(0)) u_w4s0 (
        .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val(ld_val4), .en(en), .dir(dir),
        .clr_err(clr_err), .q(q4), .tc(tc4), .edge_p(e4), .err(err4));

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    int         checks_total  = 0;
    int         checks_passed = 0;

    string      nm[3]   = '{"w8s0", "w8s1", "w4s0"};
    logic [7:0] mask[3] = '{8'hFF, 8'hFF, 8'h0F};
    bit         sat[3]  = '{1'b0, 1'b1, 1'b0};

    logic [7:0] mq[3];
    logic       medge[3];
    logic       merr[3];

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_val(input int i, input int k);
        logic [7:0] v;
        logic [7:0] qv;
        logic       ev, rv, tv;
        case (i)
            0:       begin qv = q8;          ev = e8; rv = err8; tv = tc8; end
            1:       begin qv = qs;          ev = es; rv = errs; tv = tcs; end
            default: begin qv = {4'h0, q4};  ev = e4; rv = err4; tv = tc4; end
        endcase
        case (k)
            0:       v = qv;
            1:       v = {7'd0, ev};
            2:       v = {7'd0, rv};
            default: v = {7'd0, tv};
        endcase
        return v;
    endfunction

    function automatic logic model_tc(input int i, input logic d);
        return d ? (mq[i] == mask[i]) : (mq[i] == 8'h00);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i]    = 8'h00;
            medge[i] = 1'b0;
            merr[i]  = 1'b0;
        end
    endtask

    // Compare all instances' registered outputs against the model directly.
    task automatic check_now(input string what);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s %s q", what, nm[i]), obs_val(i, 0), mq[i]);
            check_val($sformatf("%s %s edge_p", what, nm[i]), obs_val(i, 1), {7'd0, medge[i]});
            check_val($sformatf("%s %s err", what, nm[i]), obs_val(i, 2), {7'd0, merr[i]});
        end
    endtask

    // One clock transaction: drive, check tc, predict, clock, compare.
    task automatic step(input logic l, input logic [7:0] lv, input logic e,
                        input logic d, input logic c);
        logic eor;
        @(negedge clk);
        ld = l; ld_val = lv; en = e; dir = d; clr_err = c;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s tc", nm[i]), obs_val(i, 3), {7'd0, model_tc(i, d)});
        end
        for (int i = 0; i < 3; i++) begin
            eor = !l && e && model_tc(i, d);
            if (l) begin
                mq[i] = lv & mask[i];
            end else if (e && !(eor && sat[i])) begin
                mq[i] = (d ? mq[i] + 8'd1 : mq[i] - 8'd1) & mask[i];
            end
            medge[i] = eor;
            merr[i]  = eor | (merr[i] & !c);
            sb.push_back('{$sformatf("%s q", nm[i]), mq[i]});
            sb.push_back('{$sformatf("%s edge_p", nm[i]), {7'd0, medge[i]}});
            sb.push_back('{$sformatf("%s err", nm[i]), {7'd0, merr[i]}});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                exp_t x;
                if (sb.size() == 0) begin
                    check_val("scoreboard underflow", 8'h01, 8'h00);
                end else begin
                    x = sb.pop_front();
                    check_val(x.tag, obs_val(i, k), x.val);
                end
            end
        end
        $display("step ld=%0d lv=%h en=%0d dir=%0d clr=%0d | q8=%h e=%0d r=%0d | qs=%h e=%0d r=%0d | q4=%h e=%0d r=%0d",
                 l, lv, e, d, c, q8, e8, err8, qs, es, errs, q4, e4, err4);
    endtask

    // Reset pulse placed between edges, with a load pending that must be lost.
    task automatic reset_pulse(input logic [7:0] pending);
        @(negedge clk);
        ld = 1'b1; ld_val = pending; en = 1'b1; dir = 1'b1; clr_err = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now("async reset");
        @(posedge clk);
        #2;
        check_now("reset held over edge");
        rst_n = 1'b1;
        ld = 1'b0; en = 1'b0;
        $display("reset pulse, pending ld %h dropped: q8=%h qs=%h q4=%h", pending, q8, qs, q4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ld = 1'b0; ld_val = 8'h00; en = 1'b0; dir = 1'b0; clr_err = 1'b0;
        model_reset();
        #12;
        check_now("power-on reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Count up from reset.
        for (int n = 0; n < 3; n++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Load near the top, count across the end of range.
        step(1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Fresh start, count down from zero.
        reset_pulse(8'h11);
        for (int n = 0; n < 3; n++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Load beats enable; clear collides with an end-of-range edge.
        step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Build q=37 with err set, then reset between edges.
        step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h37, 1'b0, 1'b1, 1'b0);
        reset_pulse(8'hAA);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Direction toggled every cycle from zero.
        for (int n = 0; n < 4; n++) step(1'b0, 8'h00, 1'b1, n[0], 1'b0);

        // A few random transactions.
        for (int n = 0; n < 20; n++) begin
            step(($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
